regfile_alu_pipe: RTL and testbench

// Two-stage pipelined register-file + ALU datapath; the parametrised successor to our single-cycle reg-file/ALU block.
// - Issue stage: reads two operands. Results from the previous instruction are bypassed into this read.
// - EX stage: runs the ALU, writes the result back and presents a registered result.
// - Adds: sign-extended immediate, an 8-op ALU, a stall input and a valid-tagged output.
// - Sits between the decoder (AD*/ALUCtrl/ImmOP source) and the branch/test logic (EQ, a0).
//

---
 rtl/regfile_alu_pipe.sv | 144 ++++++++++++++
 tb/tb_regfile_alu_pipe.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_alu_pipe.sv
// regfile_alu_pipe
//   Two-stage register-file + ALU datapath.
//   Issue stage: reads two operands from the register array. When the
//   instruction currently in EX writes a source register, its live ALU output
//   is forwarded in place of the stale array value.
//   EX stage: evaluates the ALU, writes the result back to the array and
//   registers result/EQ with a res_valid tag.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid              an instruction is present on the issue inputs
//   stall                 freeze ID/EX, ex_valid and the array; no write-back
//   AD1, AD2, AD3         source 1, source 2, destination register indices
//   WE3                   write the ALU result to AD3 (dropped when AD3 == 0)
//   ALUsrc                0: op2 = RD2, 1: op2 = sign-extended ImmOP
//   ImmOP                 immediate operand
//   ALUCtrl               ALU opcode (ADD SUB AND OR XOR SLT SLL SRL)
//   result, EQ            registered ALU result and (op1 == op2)
//   res_valid             result/EQ belong to an instruction that left EX this cycle
//   a0                    combinational view of reg[A0_INDEX]
//
// Handshake: in_valid is sampled on each rising edge where stall is low; there
// is no back-pressure apart from stall, and res_valid is a one-cycle tag per
// completed instruction.
module regfile_alu_pipe #(
  parameter int ADDRESS_WIDTH      = 5,
  parameter int DATA_WIDTH         = 32,
  parameter int IMM_LENGTH         = 12,
  parameter int ALU_CONTROL_LENGTH = 3,
  parameter int A0_INDEX           = 10
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  input  logic                          stall,
  input  logic [ADDRESS_WIDTH-1:0]      AD1,
  input  logic [ADDRESS_WIDTH-1:0]      AD2,
  input  logic [ADDRESS_WIDTH-1:0]      AD3,
  input  logic                          WE3,
  input  logic                          ALUsrc,
  input  logic [IMM_LENGTH-1:0]         ImmOP,
  input  logic [ALU_CONTROL_LENGTH-1:0] ALUCtrl,
  output logic [DATA_WIDTH-1:0]         result,
  output logic                          EQ,
  output logic                          res_valid,
  output logic [DATA_WIDTH-1:0]         a0
);

  localparam int NREGS = 2 ** ADDRESS_WIDTH;
  localparam int SHW   = $clog2(DATA_WIDTH);

  localparam logic [ALU_CONTROL_LENGTH-1:0] OP_ADD = ALU_CONTROL_LENGTH'(0);
  localparam logic [ALU_CONTROL_LENGTH-1:0] OP_SUB = ALU_CONTROL_LENGTH'(1);
  localparam logic [ALU_CONTROL_LENGTH-1:0] OP_AND = ALU_CONTROL_LENGTH'(2);
  localparam logic [ALU_CONTROL_LENGTH-1:0] OP_OR  = ALU_CONTROL_LENGTH'(3);
  localparam logic [ALU_CONTROL_LENGTH-1:0] OP_XOR = ALU_CONTROL_LENGTH'(4);
  localparam logic [ALU_CONTROL_LENGTH-1:0] OP_SLT = ALU_CONTROL_LENGTH'(5);
  localparam logic [ALU_CONTROL_LENGTH-1:0] OP_SLL = ALU_CONTROL_LENGTH'(6);
  localparam logic [ALU_CONTROL_LENGTH-1:0] OP_SRL = ALU_CONTROL_LENGTH'(7);

  // Register array; entry 0 is never written, so it always reads 0.
  logic [DATA_WIDTH-1:0] regs [NREGS];

  // ID/EX pipeline register
  logic [DATA_WIDTH-1:0]         ex_op1;
  logic [DATA_WIDTH-1:0]         ex_op2;
  logic [ADDRESS_WIDTH-1:0]      ex_ad3;
  logic                          ex_we3;
  logic [ALU_CONTROL_LENGTH-1:0] ex_ctrl;
  logic                          ex_valid;

  logic [DATA_WIDTH-1:0] alu_out;
  logic [DATA_WIDTH-1:0] imm_sext;
  logic [DATA_WIDTH-1:0] rd1;
  logic [DATA_WIDTH-1:0] rd2;
  logic [DATA_WIDTH-1:0] op1;
  logic [DATA_WIDTH-1:0] op2;
  logic                  ex_writes;

  assign imm_sext  = {{(DATA_WIDTH-IMM_LENGTH){ImmOP[IMM_LENGTH-1]}}, ImmOP};
  assign ex_writes = ex_valid && ex_we3 && (ex_ad3 != '0);
  assign a0        = regs[A0_INDEX];

  // Operand read with forwarding from EX: the EX instruction writes back on
  // the same edge that captures this read, so the array is one cycle stale.
  always_comb begin
    rd1 = regs[AD1];
    rd2 = regs[AD2];
    if (ex_writes && (AD1 == ex_ad3)) rd1 = alu_out;
    if (ex_writes && (AD2 == ex_ad3)) rd2 = alu_out;
    op1 = rd1;
    op2 = ALUsrc ? imm_sext : rd2;
  end

  // ALU
  always_comb begin
    alu_out = '0;
    case (ex_ctrl)
      OP_ADD:  alu_out = ex_op1 + ex_op2;
      OP_SUB:  alu_out = ex_op1 - ex_op2;
      OP_AND:  alu_out = ex_op1 & ex_op2;
      OP_OR:   alu_out = ex_op1 | ex_op2;
      OP_XOR:  alu_out = ex_op1 ^ ex_op2;
      OP_SLT:  alu_out = {{(DATA_WIDTH-1){1'b0}}, ($signed(ex_op1) < $signed(ex_op2))};
      OP_SLL:  alu_out = ex_op1 << ex_op2[SHW-1:0];
      OP_SRL:  alu_out = ex_op1 >> ex_op2[SHW-1:0];
      default: alu_out = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      ex_op1    <= '0;
      ex_op2    <= '0;
      ex_ad3    <= '0;
      ex_we3    <= 1'b0;
      ex_ctrl   <= '0;
      ex_valid  <= 1'b0;
      result    <= '0;
      EQ        <= 1'b0;
      res_valid <= 1'b0;
    end else if (stall) begin
      // Everything holds; only the valid tag drops so nothing is seen twice.
      res_valid <= 1'b0;
    end else begin
      ex_valid  <= in_valid;
      res_valid <= ex_valid;
      if (in_valid) begin
        ex_op1  <= op1;
        ex_op2  <= op2;
        ex_ad3  <= AD3;
        ex_we3  <= WE3;
        ex_ctrl <= ALUCtrl;
      end
      if (ex_valid) begin
        result <= alu_out;
        EQ     <= (ex_op1 == ex_op2);
        if (ex_writes) regs[ex_ad3] <= alu_out;
      end
    end
  end

endmodule

// File: tb/tb_regfile_alu_pipe.sv
// Bench for regfile_alu_pipe. The reference model executes each accepted
// instruction to completion, in order, on an architectural register array;
// the pipelined DUT must be indistinguishable from that sequential machine.
module tb_regfile_alu_pipe;

  localparam int DW = 32;
  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3;
  localparam logic [2:0] XOR_ = 3'd4, SLT = 3'd5, SLL = 3'd6, SRL = 3'd7;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          in_valid, stall, WE3, ALUsrc;
  logic [4:0]    AD1, AD2, AD3;
  logic [11:0]   ImmOP;
  logic [2:0]    ALUCtrl;
  logic [DW-1:0] result, a0;
  logic          EQ, res_valid;

  regfile_alu_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall),
    .AD1(AD1), .AD2(AD2), .AD3(AD3), .WE3(WE3), .ALUsrc(ALUsrc),
    .ImmOP(ImmOP), .ALUCtrl(ALUCtrl),
    .result(result), .EQ(EQ), .res_valid(res_valid), .a0(a0)
  );

  // ---------------- reference model / scoreboard ----------------
  logic [DW-1:0] m_regs [32];
  logic [DW-1:0] exp_q [$];
  logic          exp_eq_q [$];
  int n_cmp  = 0;
  int n_fail = 0;

  function automatic logic [DW-1:0] alu_ref(logic [2:0] op, logic [DW-1:0] a, logic [DW-1:0] b);
    case (op)
      ADD:     return a + b;
      SUB:     return a - b;
      AND_:    return a & b;
      OR_:     return a | b;
      XOR_:    return a ^ b;
      SLT:     return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      SLL:     return a << (b % 32);
      default: return a >> (b % 32);
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    exp_q.delete();
    exp_eq_q.delete();
  endtask

  task automatic model_issue();
    logic [DW-1:0] a, b, r;
    a = m_regs[AD1];
    b = ALUsrc ? (ImmOP[11] ? {20'hFFFFF, ImmOP} : {20'h0, ImmOP}) : m_regs[AD2];
    r = alu_ref(ALUCtrl, a, b);
    exp_q.push_back(r);
    exp_eq_q.push_back(a == b);
    if (WE3 && AD3 != 5'd0) m_regs[AD3] = r;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic st, input logic [4:0] a1, input logic [4:0] a2,
                       input logic [4:0] a3, input logic we, input logic src,
                       input logic [11:0] imm, input logic [2:0] op);
    in_valid = v; stall = st; AD1 = a1; AD2 = a2; AD3 = a3;
    WE3 = we; ALUsrc = src; ImmOP = imm; ALUCtrl = op;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 12'h0, ADD);
  endtask

  // Inputs change at the falling edge; outputs are sampled at the next one.
  task automatic tick();
    if (rst_n && in_valid && !stall) model_issue();
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    model_reset();
    repeat (3) @(negedge clk);
    n_cmp++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL rst_res_valid: got %b want 0", res_valid); end
    n_cmp++; if (result !== 32'h0) begin n_fail++; $display("FAIL rst_result: got %h want 0", result); end
    n_cmp++; if (EQ !== 1'b0) begin n_fail++; $display("FAIL rst_eq: got %b want 0", EQ); end
    n_cmp++; if (a0 !== 32'h0) begin n_fail++; $display("FAIL rst_a0: got %h want 0", a0); end
    rst_n = 1'b1;
    tick();
    n_cmp++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL rst_idle_valid: got %b want 0", res_valid); end
  endtask

  task automatic test_basic();
    drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd10, 1'b1, 1'b1, 12'h005, ADD);
    tick();
    n_cmp++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid: got %b want 0", res_valid); end
    n_cmp++; if (a0 !== 32'h0) begin n_fail++; $display("FAIL basic_early_a0: got %h want 0", a0); end
    idle();
    tick();
    n_cmp++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b want 1", res_valid); end
    n_cmp++; if (result !== 32'h5) begin n_fail++; $display("FAIL basic_result: got %h want 5", result); end
    n_cmp++; if (a0 !== 32'h5) begin n_fail++; $display("FAIL basic_a0: got %h want 5", a0); end
    tick();
    n_cmp++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL basic_single_pulse: got %b want 0", res_valid); end
    exp_q.delete(); exp_eq_q.delete();
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd1, 1'b1, 1'b1, 12'h007, ADD);
    tick();
    drive(1'b1, 1'b0, 5'd1, 5'd1, 5'd2, 1'b1, 1'b0, 12'h000, SUB);
    tick();
    n_cmp++; if (res_valid !== 1'b1 || result !== 32'h7) begin n_fail++; $display("FAIL b2b_first: got v=%b %h want v=1 7", res_valid, result); end
    idle();
    tick();
    n_cmp++; if (res_valid !== 1'b1 || result !== 32'h0) begin n_fail++; $display("FAIL b2b_second: got v=%b %h want v=1 0", res_valid, result); end
    n_cmp++; if (EQ !== 1'b1) begin n_fail++; $display("FAIL b2b_eq: got %b want 1", EQ); end
    exp_q.delete(); exp_eq_q.delete();
  endtask

  task automatic test_sign_ext();
    drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd6, 1'b1, 1'b1, 12'hFFF, ADD);
    tick();
    drive(1'b1, 1'b0, 5'd6, 5'd0, 5'd7, 1'b1, 1'b0, 12'h000, SLT);
    tick();
    n_cmp++; if (result !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL sext_add: got %h want ffffffff", result); end
    drive(1'b1, 1'b0, 5'd6, 5'd0, 5'd8, 1'b1, 1'b1, 12'd28, SRL);
    tick();
    n_cmp++; if (result !== 32'h1) begin n_fail++; $display("FAIL sext_slt: got %h want 1", result); end
    idle();
    tick();
    n_cmp++; if (res_valid !== 1'b1 || result !== 32'h0000000F) begin n_fail++; $display("FAIL sext_srl: got v=%b %h want v=1 0000000f", res_valid, result); end
    exp_q.delete(); exp_eq_q.delete();
  endtask

  task automatic test_x0();
    drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 12'h009, ADD);
    tick();
    drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 12'h000, ADD);
    tick();
    n_cmp++; if (result !== 32'h9) begin n_fail++; $display("FAIL x0_write_result: got %h want 9", result); end
    drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd14, 1'b1, 1'b0, 12'h000, OR_);
    tick();
    n_cmp++; if (res_valid !== 1'b1 || result !== 32'h0) begin n_fail++; $display("FAIL x0_bypass_read: got v=%b %h want v=1 0", res_valid, result); end
    idle();
    tick();
    n_cmp++; if (result !== 32'h0) begin n_fail++; $display("FAIL x0_array_read: got %h want 0", result); end
    exp_q.delete(); exp_eq_q.delete();
  endtask

  task automatic test_stall();
    drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd4, 1'b1, 1'b1, 12'h003, ADD);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 5'd0, 5'd0, 5'd4, 1'b1, 1'b1, 12'd100, ADD);
      tick();
      n_cmp++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL stall_valid%0d: got %b want 0", i, res_valid); end
      n_cmp++; if (result !== 32'h0) begin n_fail++; $display("FAIL stall_hold%0d: got %h want 0", i, result); end
    end
    idle();
    tick();
    n_cmp++; if (res_valid !== 1'b1 || result !== 32'h3) begin n_fail++; $display("FAIL stall_release: got v=%b %h want v=1 3", res_valid, result); end
    tick();
    n_cmp++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL stall_once: got %b want 0", res_valid); end
    drive(1'b1, 1'b0, 5'd4, 5'd0, 5'd9, 1'b1, 1'b0, 12'h000, ADD);
    tick();
    idle();
    tick();
    n_cmp++; if (res_valid !== 1'b1 || result !== 32'h3) begin n_fail++; $display("FAIL stall_x4: got v=%b %h want v=1 3", res_valid, result); end
    exp_q.delete(); exp_eq_q.delete();
  endtask

  task automatic test_reset_midflight();
    drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd12, 1'b1, 1'b0, 12'h000, ADD);
    tick();
    drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 12'h001, ADD);
    tick();
    n_cmp++; if (res_valid !== 1'b1 || EQ !== 1'b1) begin n_fail++; $display("FAIL mid_pre_eq: got v=%b eq=%b want v=1 eq=1", res_valid, EQ); end
    rst_n = 1'b0;
    idle();
    #1;
    n_cmp++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid: got %b want 0", res_valid); end
    n_cmp++; if (EQ !== 1'b0) begin n_fail++; $display("FAIL mid_eq: got %b want 0", EQ); end
    n_cmp++; if (result !== 32'h0) begin n_fail++; $display("FAIL mid_result: got %h want 0", result); end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    n_cmp++; if (a0 !== 32'h0) begin n_fail++; $display("FAIL mid_a0: got %h want 0", a0); end
    drive(1'b1, 1'b0, 5'd5, 5'd0, 5'd11, 1'b1, 1'b0, 12'h000, ADD);
    tick();
    idle();
    tick();
    n_cmp++; if (res_valid !== 1'b1 || result !== 32'h0) begin n_fail++; $display("FAIL mid_x5: got v=%b %h want v=1 0", res_valid, result); end
    exp_q.delete(); exp_eq_q.delete();
  endtask

  task automatic test_random();
    logic [DW-1:0] e;
    logic          ee;
    for (int c = 0; c < 420; c++) begin
      if (c < 400) begin
        drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 6) == 0),
              5'($urandom_range(0, 11)), 5'($urandom_range(0, 11)), 5'($urandom_range(0, 11)),
              ($urandom_range(0, 4) != 0), 1'($urandom_range(0, 1)),
              12'($urandom), 3'($urandom_range(0, 7)));
      end else if (c < 412) begin
        // read back x0..x11 without writing
        drive(1'b1, 1'b0, 5'(c - 400), 5'd0, 5'd0, 1'b0, 1'b0, 12'h0, ADD);
      end else begin
        idle();
      end
      tick();
      if (res_valid === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL rnd_extra c=%0d: got result %h want none", c, result);
        end else begin
          e  = exp_q.pop_front();
          ee = exp_eq_q.pop_front();
          if (result !== e || EQ !== ee) begin
            n_fail++; $display("FAIL rnd_result c=%0d: got %h eq=%b want %h eq=%b", c, result, EQ, e, ee);
          end
        end
      end
    end
    n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rnd_missing: got %0d left want 0", exp_q.size()); end
    n_cmp++; if (a0 !== m_regs[10]) begin n_fail++; $display("FAIL rnd_a0: got %h want %h", a0, m_regs[10]); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_sign_ext();
    test_x0();
    test_stall();
    test_reset_midflight();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
